hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core: tracks destination registers of in-flight instructions in its own EX/MEM/WB shadow registers and drives the EX-stage forwarding-mux selects (FA/FB), IF/ID stall enables, ID/EX and IF/ID flushes, and the multi-cycle mult/div interlock. Sits beside the pipeline registers and receives decoded fields from ID plus branch resolution from EX.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_mdu_fsm.sv | 52 +++++
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the pipeline hazard controller.
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_e;

   typedef struct packed {
      logic valid;
      logic regwr;
      logic memrd;
      logic mduop;
   } ex_flags_t;

   localparam ex_flags_t EX_BUBBLE = '0;

endpackage

// File: rtl/hazard_mdu_fsm.sv
// rtl/hazard_mdu_fsm.sv - mult/div occupancy tracker and interlock request.
module hazard_mdu_fsm
   import hazard_pkg::*;
#(
   parameter int MDU_LAT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic ex_mduop,
   input  logic id_mdu_use,
   output logic mdu_busy,
   output logic mdu_stall
);

   localparam int CNT_W = $clog2(MDU_LAT);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Busy spans MDU_LAT cycles: count runs MDU_LAT-1 down to 0 inclusive.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MDU_IDLE: begin
            if (ex_mduop) begin
               state_d = MDU_BUSY;
               cnt_d   = CNT_W'(MDU_LAT - 1);
            end
         end
         MDU_BUSY: begin
            if (cnt_q == '0) state_d = MDU_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = MDU_IDLE;
      endcase
   end

   assign mdu_busy  = (state_q == MDU_BUSY);
   assign mdu_stall = id_mdu_use & (mdu_busy | ex_mduop);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding selects, load-use/MDU interlocks and branch flushes
// for the 5-stage core, driven from private EX/MEM/WB shadow registers.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MDU_LAT = 32,
   parameter int REG_AW  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Valid_D,
   input  logic [REG_AW-1:0] Rs_D,
   input  logic [REG_AW-1:0] Rt_D,
   input  logic              UsesRt_D,
   input  logic [REG_AW-1:0] Dst_D,
   input  logic              RegWrite_D,
   input  logic              MemRead_D,
   input  logic              MduOp_D,
   input  logic              MduUse_D,
   input  logic              BranchTaken_E,
   output logic [1:0]        FA,
   output logic [1:0]        FB,
   output logic              Stall_F,
   output logic              Stall_D,
   output logic              Flush_D,
   output logic              Flush_E,
   output logic              MduBusy
);

   ex_flags_t         e_flg_q, e_flg_d;
   logic [REG_AW-1:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d, e_dst_q, e_dst_d;
   logic              m_valid_q, m_valid_d, m_regwr_q, m_regwr_d;
   logic [REG_AW-1:0] m_dst_q, m_dst_d;
   logic              w_valid_q, w_valid_d, w_regwr_q, w_regwr_d;
   logic [REG_AW-1:0] w_dst_q, w_dst_d;
   logic              load_use, mdu_stall, stall_req;

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                          input logic mv, input logic mr, input logic [REG_AW-1:0] md,
                                          input logic wv, input logic wr, input logic [REG_AW-1:0] wd);
      if (mv && mr && md != '0 && md == src)      return FWD_MEM;
      else if (wv && wr && wd != '0 && wd == src) return FWD_WB;
      else                                        return FWD_RF;
   endfunction

   hazard_mdu_fsm #(.MDU_LAT(MDU_LAT)) u_mdu (
      .clk        (clk),
      .rst        (rst),
      .ex_mduop   (e_flg_q.mduop),
      .id_mdu_use (MduUse_D & Valid_D),
      .mdu_busy   (MduBusy),
      .mdu_stall  (mdu_stall)
   );

   always_comb begin
      FA = fwd_sel(e_rs_q, m_valid_q, m_regwr_q, m_dst_q, w_valid_q, w_regwr_q, w_dst_q);
      FB = fwd_sel(e_rt_q, m_valid_q, m_regwr_q, m_dst_q, w_valid_q, w_regwr_q, w_dst_q);
      load_use = e_flg_q.valid & e_flg_q.memrd & (e_dst_q != '0) & Valid_D &
                 ((e_dst_q == Rs_D) | (UsesRt_D & (e_dst_q == Rt_D)));
      stall_req = load_use | mdu_stall;
      // A taken branch kills the stalled instruction anyway, so it wins over any hold.
      Stall_F = stall_req & ~BranchTaken_E;
      Stall_D = stall_req & ~BranchTaken_E;
      Flush_D = BranchTaken_E;
      Flush_E = stall_req | BranchTaken_E;
   end

   always_comb begin
      e_flg_d = EX_BUBBLE;
      e_rs_d  = '0;
      e_rt_d  = '0;
      e_dst_d = '0;
      if (!Flush_E) begin
         e_flg_d.valid = Valid_D;
         e_flg_d.regwr = RegWrite_D;
         e_flg_d.memrd = MemRead_D;
         e_flg_d.mduop = MduOp_D & Valid_D;
         e_rs_d        = Rs_D;
         e_rt_d        = Rt_D;
         e_dst_d       = Dst_D;
      end
      m_valid_d = e_flg_q.valid;
      m_regwr_d = e_flg_q.regwr;
      m_dst_d   = e_dst_q;
      w_valid_d = m_valid_q;
      w_regwr_d = m_regwr_q;
      w_dst_d   = m_dst_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_flg_q   <= EX_BUBBLE;
         e_rs_q    <= '0;
         e_rt_q    <= '0;
         e_dst_q   <= '0;
         m_valid_q <= 1'b0;
         m_regwr_q <= 1'b0;
         m_dst_q   <= '0;
         w_valid_q <= 1'b0;
         w_regwr_q <= 1'b0;
         w_dst_q   <= '0;
      end else begin
         e_flg_q   <= e_flg_d;
         e_rs_q    <= e_rs_d;
         e_rt_q    <= e_rt_d;
         e_dst_q   <= e_dst_d;
         m_valid_q <= m_valid_d;
         m_regwr_q <= m_regwr_d;
         m_dst_q   <= m_dst_d;
         w_valid_q <= w_valid_d;
         w_regwr_q <= w_regwr_d;
         w_dst_q   <= w_dst_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl (MDU_LAT=4).
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       Valid_D, UsesRt_D, RegWrite_D, MemRead_D, MduOp_D, MduUse_D, BranchTaken_E;
   logic [4:0] Rs_D, Rt_D, Dst_D;
   logic [1:0] FA, FB;
   logic       Stall_F, Stall_D, Flush_D, Flush_E, MduBusy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string      tag;
      logic [1:0] fa, fb;
      logic       st, fd, fe, bz;
   } exp_t;

   exp_t sb[$];

   hazard_ctrl #(.MDU_LAT(4), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .Valid_D(Valid_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .UsesRt_D(UsesRt_D),
      .Dst_D(Dst_D), .RegWrite_D(RegWrite_D), .MemRead_D(MemRead_D), .MduOp_D(MduOp_D),
      .MduUse_D(MduUse_D), .BranchTaken_E(BranchTaken_E), .FA(FA), .FB(FB),
      .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E), .MduBusy(MduBusy)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input string what, input logic [1:0] got, input logic [1:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s.%s observed=%0b expected=%0b", tag, what, got, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                           input logic st, input logic fd, input logic fe, input logic bz);
      exp_t e;
      e.tag = tag; e.fa = fa; e.fb = fb; e.st = st; e.fd = fd; e.fe = fe; e.bz = bz;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      tests++;
      assert (sb.size() > 0) else begin
         fails++;
         $error("FAIL scoreboard observed=empty expected=entry");
         return;
      end
      e = sb.pop_front();
      cmp(e.tag, "FA", FA, e.fa);
      cmp(e.tag, "FB", FB, e.fb);
      cmp(e.tag, "Stall_F", {1'b0, Stall_F}, {1'b0, e.st});
      cmp(e.tag, "Stall_D", {1'b0, Stall_D}, {1'b0, e.st});
      cmp(e.tag, "Flush_D", {1'b0, Flush_D}, {1'b0, e.fd});
      cmp(e.tag, "Flush_E", {1'b0, Flush_E}, {1'b0, e.fe});
      cmp(e.tag, "MduBusy", {1'b0, MduBusy}, {1'b0, e.bz});
   endtask

   task automatic go(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                     input logic st, input logic fd, input logic fe, input logic bz);
      push_exp(tag, fa, fb, st, fd, fe, bz);
      #4;
      check_pop();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id(input logic v, input int rs, input int rt, input logic ur, input int dst,
                     input logic rw, input logic mr, input logic mo, input logic mu);
      Valid_D = v; Rs_D = 5'(rs); Rt_D = 5'(rt); UsesRt_D = ur; Dst_D = 5'(dst);
      RegWrite_D = rw; MemRead_D = mr; MduOp_D = mo; MduUse_D = mu; BranchTaken_E = 1'b0;
   endtask

   task automatic nop();
      id(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b0;
      nop();
      #12;
      go("reset", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); rst = 1'b1;

      // forwarding distance: MEM, WB, none
      id(1, 1, 2, 1, 3, 1, 0, 0, 0);    go("add_id", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 3, 5, 1, 4, 1, 0, 0, 0); go("sub_id", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("fwd_mem", FWD_MEM, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("drain1", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 1, 2, 1, 3, 1, 0, 0, 0); go("add2", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("gap1", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 3, 5, 1, 4, 1, 0, 0, 0); go("sub2", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("fwd_wb", FWD_WB, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 1, 2, 1, 3, 1, 0, 0, 0); go("add3", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("gap2a", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("gap2b", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 3, 5, 1, 4, 1, 0, 0, 0); go("sub3", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("fwd_none", FWD_RF, FWD_RF, 0, 0, 0, 0);

      // MEM beats WB on rt
      tick(); id(1, 1, 2, 1, 3, 1, 0, 0, 0); go("wr3_a", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 6, 7, 1, 3, 1, 0, 0, 0); go("wr3_b", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 1, 3, 1, 4, 1, 0, 0, 0); go("rd3", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("mem_beats_wb", FWD_RF, FWD_MEM, 0, 0, 0, 0);

      // load-use on rs: one bubble, then WB forward
      tick(); id(1, 1, 0, 0, 3, 1, 1, 0, 0); go("lw3", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 3, 1, 1, 4, 1, 0, 0, 0); go("load_use", FWD_RF, FWD_RF, 1, 0, 1, 0);
      tick();                           go("lu_bubble", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("lu_fwd_wb", FWD_WB, FWD_RF, 0, 0, 0, 0);

      // load-use on rt, and rt match ignored when UsesRt is low
      tick(); id(1, 1, 0, 0, 5, 1, 1, 0, 0); go("lw5", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 2, 5, 1, 6, 1, 0, 0, 0); go("load_use_rt", FWD_RF, FWD_RF, 1, 0, 1, 0);
      tick();                           go("lu_rt_bubble", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 1, 0, 0, 5, 1, 1, 0, 0); go("fwd_wb_rt", FWD_RF, FWD_WB, 0, 0, 0, 0);
      tick(); id(1, 2, 5, 0, 6, 1, 0, 0, 0); go("rt_unused", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("fwd_mem_rt", FWD_RF, FWD_MEM, 0, 0, 0, 0);

      // $0 never forwards or stalls
      tick(); id(1, 1, 0, 0, 0, 1, 1, 0, 0); go("lw0", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 0, 0, 1, 7, 1, 0, 0, 0); go("zero_no_stall", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("zero_no_fwd", FWD_RF, FWD_RF, 0, 0, 0, 0);

      // branch overrides load-use stall
      tick(); id(1, 1, 0, 0, 3, 1, 1, 0, 0); go("lw3_br", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 3, 1, 1, 4, 1, 0, 0, 0); BranchTaken_E = 1'b1;
      go("branch_over_lu", FWD_RF, FWD_RF, 0, 1, 1, 0);
      tick(); nop();                    go("after_branch", FWD_RF, FWD_RF, 0, 0, 0, 0);

      // mult then mflo: stall while op in EX and through 4 BUSY cycles
      tick(); id(1, 1, 2, 1, 0, 0, 0, 1, 1); go("mult_id", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); id(1, 0, 0, 0, 4, 1, 0, 0, 1); go("mdu_ex_stall", FWD_RF, FWD_RF, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); go($sformatf("mdu_busy%0d", i), FWD_RF, FWD_RF, 1, 0, 1, 1);
      end
      tick();                           go("mdu_release", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("mflo_ex", FWD_RF, FWD_RF, 0, 0, 0, 0);

      // branch during BUSY: flush, counting continues
      tick(); id(1, 1, 2, 1, 0, 0, 0, 1, 1); go("mult2_id", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("mult2_ex", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop(); BranchTaken_E = 1'b1;
      go("branch_in_busy", FWD_RF, FWD_RF, 0, 1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         tick(); nop(); go($sformatf("busy_cont%0d", i), FWD_RF, FWD_RF, 0, 0, 0, 1);
      end
      tick();                           go("busy_done", FWD_RF, FWD_RF, 0, 0, 0, 0);

      // reset mid-BUSY
      tick(); id(1, 1, 2, 1, 0, 0, 0, 1, 1); go("mult3_id", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick(); nop();                    go("mult3_ex", FWD_RF, FWD_RF, 0, 0, 0, 0);
      tick();                           go("mult3_busy", FWD_RF, FWD_RF, 0, 0, 0, 1);
      #1 rst = 1'b0;
      push_exp("reset_mid_busy", FWD_RF, FWD_RF, 0, 0, 0, 0);
      #1 check_pop();
      tick(); rst = 1'b1; id(1, 0, 0, 0, 4, 1, 0, 0, 1);
      go("post_reset_idle", FWD_RF, FWD_RF, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
